// File: rtl/matrix_scroll_buffer.sv
// matrix_scroll_buffer
//
// Feeds the 5x7 LED matrix column multiplexer. Holds a message as MSG_LEN
// column bitmaps (7 rows each) and presents a 5-column window on
// col_4 (leftmost) .. col_0 (rightmost). A timed FSM (IDLE / RUN / PAUSE)
// scrolls the window one column every SCROLL_DIV clocks. After each wrap it
// optionally holds for PAUSE_STEPS scroll periods.
//
// Optional feature macro: SCROLL_BLANK_EN
//   defined   - virtual length MSG_LEN+5. Positions past the message read as
//               blank, so the text scrolls fully off before restarting.
//   undefined - virtual length MSG_LEN. The message is circular.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high; clears all state and memory
//   wr_en          message memory write strobe
//   wr_addr        column index to write (>= MSG_LEN ignored)
//   wr_data        column bitmap, bit 0 = top row
//   start          begin scrolling (level, sampled in IDLE only)
//   stop           abort scrolling; priority over start and ticks
//   col_4..col_0   registered window columns, col_4 = mem[pos]
//   busy           registered, high in RUN or PAUSE
//   wrap           one-clock pulse when pos wraps to 0

module matrix_scroll_buffer #(
    parameter int unsigned MSG_LEN     = 16,
    parameter int unsigned SCROLL_DIV  = 1000,
    parameter int unsigned PAUSE_STEPS = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [6:0]                 wr_data,
    input  logic                       start,
    input  logic                       stop,
    output logic [6:0]                 col_4,
    output logic [6:0]                 col_3,
    output logic [6:0]                 col_2,
    output logic [6:0]                 col_1,
    output logic [6:0]                 col_0,
    output logic                       busy,
    output logic                       wrap
);

`ifdef SCROLL_BLANK_EN
    localparam int unsigned VLEN = MSG_LEN + 5;
`else
    localparam int unsigned VLEN = MSG_LEN;
`endif

    localparam int unsigned AW         = $clog2(MSG_LEN);
    localparam int unsigned PW         = $clog2(VLEN);
    localparam int unsigned TW         = $clog2(SCROLL_DIV);
    localparam int unsigned SW         = (PAUSE_STEPS > 1) ? $clog2(PAUSE_STEPS) : 1;
    localparam int unsigned PAUSE_LAST = (PAUSE_STEPS > 0) ? PAUSE_STEPS - 1 : 0;

    localparam logic [PW-1:0] POS_LAST  = PW'(VLEN - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCROLL_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(PAUSE_LAST);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] pause_q, pause_d;
    logic          wrap_d;
    logic          tick_done;

    logic [6:0]    mem_q  [MSG_LEN];
    logic [6:0]    cols_q [5];
    logic [6:0]    win    [5];
    int unsigned   win_idx [5];
    logic          busy_q, wrap_q;

    // Message memory: writes accepted in every state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MSG_LEN); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < MSG_LEN)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Window read from the current (pre-edge) memory and position, so a write
    // or a pos change becomes visible on the outputs one clock later.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            win_idx[k] = 32'(pos_q) + 32'(k);
            // k <= 4 < MSG_LEN, so one subtraction covers the modulo.
            if (win_idx[k] >= VLEN) begin
                win_idx[k] = win_idx[k] - VLEN;
            end
            win[k] = (win_idx[k] < MSG_LEN) ? mem_q[win_idx[k][AW-1:0]] : 7'h00;
        end
    end

    assign tick_done = (tick_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tick_d  = tick_q;
        pause_d = pause_q;
        wrap_d  = 1'b0;

        if (stop) begin
            state_d = StIdle;
            pos_d   = '0;
            tick_d  = '0;
            pause_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pos_d   = '0;
                    tick_d  = '0;
                    pause_d = '0;
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (tick_done) begin
                        tick_d = '0;
                        if (pos_q == POS_LAST) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                            if (PAUSE_STEPS > 0) begin
                                state_d = StPause;
                            end
                        end else begin
                            pos_d = pos_q + PW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                StPause: begin
                    if (tick_done) begin
                        tick_d = '0;
                        if (pause_q == STEP_LAST) begin
                            pause_d = '0;
                            state_d = StRun;
                        end else begin
                            pause_d = pause_q + SW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    pos_d   = '0;
                    tick_d  = '0;
                    pause_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pos_q   <= '0;
            tick_q  <= '0;
            pause_q <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                cols_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
            pause_q <= pause_d;
            busy_q  <= (state_d != StIdle);
            wrap_q  <= wrap_d;
            for (int k = 0; k < 5; k++) begin
                cols_q[k] <= win[k];
            end
        end
    end

    assign col_4 = cols_q[0];
    assign col_3 = cols_q[1];
    assign col_2 = cols_q[2];
    assign col_1 = cols_q[3];
    assign col_0 = cols_q[4];
    assign busy  = busy_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_matrix_scroll_buffer.sv
// Self-checking bench for matrix_scroll_buffer (MSG_LEN=8, SCROLL_DIV=4,
// PAUSE_STEPS=2, circular message). The reference model tracks the number of
// clocks since scrolling began and derives pos from that count arithmetically.
module tb_matrix_scroll_buffer;

    localparam int L  = 8;
    localparam int D  = 4;
    localparam int PS = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [6:0] wr_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [6:0] col_4, col_3, col_2, col_1, col_0;
    logic       busy, wrap;

    logic [6:0] dut_cols [5];
    assign dut_cols[0] = col_4;
    assign dut_cols[1] = col_3;
    assign dut_cols[2] = col_2;
    assign dut_cols[3] = col_1;
    assign dut_cols[4] = col_0;

    matrix_scroll_buffer #(
        .MSG_LEN    (L),
        .SCROLL_DIV (D),
        .PAUSE_STEPS(PS)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start  (start),
        .stop   (stop),
        .col_4  (col_4),
        .col_3  (col_3),
        .col_2  (col_2),
        .col_1  (col_1),
        .col_0  (col_0),
        .busy   (busy),
        .wrap   (wrap)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [6:0] m_mem [L];
    logic [6:0] m_cols [5];
    logic       m_busy = 1'b0;
    logic       m_wrap = 1'b0;
    int         run_n = -1;  // clocks since start was accepted; -1 when idle

    // First lap: pos advances every D clocks. Later laps: pos 0 lasts for the
    // pause plus one normal step, then 1..L-1 every D clocks.
    function automatic int pos_at(int n);
        int m;
        if (n < L * D) return n / D;
        m = (n - L * D) % ((L + PS) * D);
        if (m < (PS + 1) * D) return 0;
        return m / D - PS;
    endfunction

    function automatic bit is_wrap(int n);
        return (n >= L * D) && (((n - L * D) % ((L + PS) * D)) == 0);
    endfunction

    function automatic int cur_pos();
        return (run_n < 0) ? 0 : pos_at(run_n);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < L; i++) m_mem[i] = '0;
        for (int k = 0; k < 5; k++) m_cols[k] = '0;
        run_n  = -1;
        m_busy = 1'b0;
        m_wrap = 1'b0;
    endtask

    // One clock: advance DUT and model, then settle for sampling.
    task automatic step();
        int p;
        @(posedge clock);
        p = cur_pos();
        for (int k = 0; k < 5; k++) m_cols[k] = m_mem[(p + k) % L];
        if (stop) run_n = -1;
        else if (run_n < 0) begin
            if (start) run_n = 0;
        end else run_n = run_n + 1;
        m_busy = (run_n >= 0);
        m_wrap = (run_n >= 0) && is_wrap(run_n);
        if (wr_en) m_mem[wr_addr] = wr_data;
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        @(posedge clock);
        #2;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dut_cols[k] !== 7'h00) begin
                failures++;
                $display("FAIL reset col_%0d: got %h want 00", 4 - k, dut_cols[k]);
            end
        end
        checks++;
        if (busy !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset flags: got busy=%b wrap=%b want 0 0", busy, wrap);
        end
        reset = 1'b0;
    endtask

    task automatic test_static();
        for (int i = 0; i < L; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 7'(i + 1);
            step();
        end
        wr_en = 1'b0;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dut_cols[k] !== 7'(k + 1) || dut_cols[k] !== m_cols[k]) begin
                failures++;
                $display("FAIL static col_%0d: got %h want %h", 4 - k, dut_cols[k], 7'(k + 1));
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL static busy: got %b want 0", busy);
        end
    endtask

    task automatic test_scroll_wrap_pause();
        int dut_wraps = 0, mdl_wraps = 0, run_len = 0, max_run = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL scroll busy after start: got %b want 1", busy);
        end
        for (int c = 0; c < 70; c++) begin
            step();
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (dut_cols[k] !== m_cols[k]) begin
                    failures++;
                    $display("FAIL scroll col_%0d n=%0d: got %h want %h",
                             4 - k, run_n, dut_cols[k], m_cols[k]);
                end
            end
            checks++;
            if (busy !== m_busy || wrap !== m_wrap) begin
                failures++;
                $display("FAIL scroll flags n=%0d: got busy=%b wrap=%b want %b %b",
                         run_n, busy, wrap, m_busy, m_wrap);
            end
            if (wrap === 1'b1) begin
                dut_wraps++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else run_len = 0;
            if (m_wrap) mdl_wraps++;
        end
        checks++;
        if (dut_wraps !== mdl_wraps || max_run !== 1) begin
            failures++;
            $display("FAIL wrap pulses: got count=%0d width=%0d want count=%0d width=1",
                     dut_wraps, max_run, mdl_wraps);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_stop_priority();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && cur_pos() != 3; c++) step();
        checks++;
        if (cur_pos() != 3) begin
            failures++;
            $display("FAIL stop setup: got pos=%0d want 3", cur_pos());
        end
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0 || wrap !== 1'b0 || busy !== m_busy) begin
            failures++;
            $display("FAIL stop flags: got busy=%b wrap=%b want 0 0", busy, wrap);
        end
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dut_cols[k] !== m_cols[k]) begin
                failures++;
                $display("FAIL stop col_%0d: got %h want %h", 4 - k, dut_cols[k], m_cols[k]);
            end
        end
    endtask

    task automatic test_live_write();
        start = 1'b1;
        step();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 7'h7F;
        step();
        wr_en = 1'b0;
        step();
        checks++;
        if (col_2 !== 7'h7F) begin
            failures++;
            $display("FAIL live write col_2: got %h want 7f", col_2);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dut_cols[k] !== m_cols[k]) begin
                failures++;
                $display("FAIL live col_%0d: got %h want %h", 4 - k, dut_cols[k], m_cols[k]);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset_mid_pause();
        start = 1'b1;
        step();
        start = 1'b0;
        while (run_n < L * D + 5 && run_n >= 0) step();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dut_cols[k] !== 7'h00) begin
                failures++;
                $display("FAIL async reset col_%0d: got %h want 00", 4 - k, dut_cols[k]);
            end
        end
        checks++;
        if (busy !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL async reset flags: got busy=%b wrap=%b want 0 0", busy, wrap);
        end
        #1;
        reset = 1'b0;
        model_clear();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (dut_cols[k] !== m_cols[k] || dut_cols[k] !== 7'h00) begin
                    failures++;
                    $display("FAIL post-reset col_%0d: got %h want 00", 4 - k, dut_cols[k]);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL post-reset busy: got %b want 1", busy);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, L - 1));
            wr_data = 7'($urandom);
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 47) == 0);
            step();
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (dut_cols[k] !== m_cols[k]) begin
                    failures++;
                    $display("FAIL random col_%0d c=%0d: got %h want %h",
                             4 - k, c, dut_cols[k], m_cols[k]);
                end
            end
            checks++;
            if (busy !== m_busy || wrap !== m_wrap) begin
                failures++;
                $display("FAIL random flags c=%0d: got busy=%b wrap=%b want %b %b",
                         c, busy, wrap, m_busy, m_wrap);
            end
        end
        wr_en = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static();
        test_scroll_wrap_pause();
        test_stop_priority();
        test_live_write();
        test_reset_mid_pause();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
